// File: rtl/xadac_mux_pkg.sv
// Payload types shared by xadac_mux and the xadac_if bundle.
package xadac_mux_pkg;

  localparam int unsigned IdWidth = 3;
  localparam int unsigned InstrW  = 32;
  localparam int unsigned XlenW   = 32;
  localparam int unsigned RegIdxW = 5;

  typedef logic [IdWidth-1:0] id_t;

  typedef struct packed {
    id_t               id;
    logic [InstrW-1:0] instr;
  } dec_req_t;

  typedef struct packed {
    id_t                id;
    logic               accept;
    logic [RegIdxW-1:0] rd;
  } dec_rsp_t;

  typedef struct packed {
    id_t               id;
    logic [InstrW-1:0] instr;
    logic [XlenW-1:0]  rs1;
    logic [XlenW-1:0]  rs2;
  } exe_req_t;

  typedef struct packed {
    id_t                id;
    logic [RegIdxW-1:0] rd;
    logic [XlenW-1:0]   data;
  } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// xadac coprocessor port: decode and execute channels, each a req/rsp valid-ready pair.
interface xadac_if;
  import xadac_mux_pkg::*;

  dec_req_t dec_req;
  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_rsp_t dec_rsp;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;

  exe_req_t exe_req;
  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_rsp_t exe_rsp;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;

  modport mst (
    output dec_req, dec_req_valid, dec_rsp_ready,
    output exe_req, exe_req_valid, exe_rsp_ready,
    input  dec_req_ready, dec_rsp, dec_rsp_valid,
    input  exe_req_ready, exe_rsp, exe_rsp_valid
  );

  modport slv (
    input  dec_req, dec_req_valid, dec_rsp_ready,
    input  exe_req, exe_req_valid, exe_rsp_ready,
    output dec_req_ready, dec_rsp, dec_rsp_valid,
    output exe_req_ready, exe_rsp, exe_rsp_valid
  );

endinterface

// File: rtl/xadac_mux.sv
// N-to-1 xadac mux: round-robin request arbitration and id-owner response routing per channel.
// Optional XADAC_MUX_STATS_EN adds grant and id-stall counters.
module xadac_mux
  import xadac_mux_pkg::*;
#(
  parameter int unsigned NumPorts = 2
) (
  input  logic                clk,
  input  logic                rstn,

  input  dec_req_t            mst_dec_req [NumPorts],
  input  logic [NumPorts-1:0] mst_dec_req_vld,
  output logic [NumPorts-1:0] mst_dec_req_rdy,
  output dec_rsp_t            mst_dec_rsp,
  output logic [NumPorts-1:0] mst_dec_rsp_vld,
  input  logic [NumPorts-1:0] mst_dec_rsp_rdy,

  input  exe_req_t            mst_exe_req [NumPorts],
  input  logic [NumPorts-1:0] mst_exe_req_vld,
  output logic [NumPorts-1:0] mst_exe_req_rdy,
  output exe_rsp_t            mst_exe_rsp,
  output logic [NumPorts-1:0] mst_exe_rsp_vld,
  input  logic [NumPorts-1:0] mst_exe_rsp_rdy,

  xadac_if.mst                slv,

  output logic                err_unmapped
`ifdef XADAC_MUX_STATS_EN
  ,
  output logic [31:0]         stat_dec_grants [NumPorts],
  output logic [31:0]         stat_exe_grants [NumPorts],
  output logic [31:0]         stat_id_stalls
`endif
);

  localparam int unsigned PortIdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned NumIds   = 2 ** IdWidth;
  localparam int unsigned NumCh    = 2;

  typedef logic [PortIdxW-1:0] port_idx_t;

  // Channel-generic view: index 0 = dec, 1 = exe
  logic [NumPorts-1:0] ch_req_vld     [NumCh];
  id_t                 ch_req_id      [NumCh][NumPorts];
  logic                ch_slv_req_rdy [NumCh];
  logic                ch_slv_rsp_vld [NumCh];
  id_t                 ch_rsp_id      [NumCh];
  logic [NumPorts-1:0] ch_rsp_rdy     [NumCh];

  port_idx_t           ch_gnt         [NumCh];
  logic                ch_gnt_vld     [NumCh];
  logic [NumPorts-1:0] ch_req_rdy     [NumCh];
  logic [NumPorts-1:0] ch_rsp_vld     [NumCh];
  logic                ch_slv_rsp_rdy [NumCh];
  logic                ch_unmapped    [NumCh];
`ifdef XADAC_MUX_STATS_EN
  logic                ch_stall       [NumCh];
`endif

  always_comb begin
    ch_req_vld[0]     = mst_dec_req_vld;
    ch_req_vld[1]     = mst_exe_req_vld;
    ch_slv_req_rdy[0] = slv.dec_req_ready;
    ch_slv_req_rdy[1] = slv.exe_req_ready;
    ch_slv_rsp_vld[0] = slv.dec_rsp_valid;
    ch_slv_rsp_vld[1] = slv.exe_rsp_valid;
    ch_rsp_id[0]      = slv.dec_rsp.id;
    ch_rsp_id[1]      = slv.exe_rsp.id;
    ch_rsp_rdy[0]     = mst_dec_rsp_rdy;
    ch_rsp_rdy[1]     = mst_exe_rsp_rdy;
    for (int p = 0; p < int'(NumPorts); p++) begin
      ch_req_id[0][p] = mst_dec_req[p].id;
      ch_req_id[1][p] = mst_exe_req[p].id;
    end
  end

  for (genvar c = 0; c < int'(NumCh); c++) begin : g_ch
    logic [NumIds-1:0]   busy;
    port_idx_t           owner [NumIds];
    port_idx_t           rr_ptr;
    port_idx_t           lock_gnt;
    logic                lock;
    port_idx_t           gnt;
    logic                gnt_vld;
    logic                req_hs;
    logic [NumPorts-1:0] elig;
    logic [NumPorts-1:0] masked;
    port_idx_t           rsp_owner;
    logic                rsp_mapped;
    logic                slv_rsp_rdy;
    logic                rsp_hs;
    port_idx_t           rr_next;

    // Busy ids are read from the registered table only, so a freed id is usable next cycle
    always_comb begin
      elig   = '0;
      masked = '0;
      for (int p = 0; p < int'(NumPorts); p++) begin
        elig[p]   = ch_req_vld[c][p] && !busy[ch_req_id[c][p]];
        masked[p] = ch_req_vld[c][p] &&  busy[ch_req_id[c][p]];
      end
    end

    // Round-robin pick from rr_ptr; a pending lock overrides arbitration
    always_comb begin
      int unsigned idx;
      idx     = 0;
      gnt     = rr_ptr;
      gnt_vld = 1'b0;
      if (lock) begin
        gnt     = lock_gnt;
        gnt_vld = ch_req_vld[c][lock_gnt];
      end else begin
        for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
          idx = 32'(rr_ptr) + 32'(k);
          if (idx >= NumPorts) idx = idx - NumPorts;
          if (elig[port_idx_t'(idx)]) begin
            gnt     = port_idx_t'(idx);
            gnt_vld = 1'b1;
          end
        end
      end
      gnt_vld = gnt_vld && rstn;
    end

    always_comb begin
      req_hs      = gnt_vld && ch_slv_req_rdy[c];
      rr_next     = (gnt == port_idx_t'(NumPorts - 1)) ? '0 : gnt + port_idx_t'(1);
      rsp_owner   = owner[ch_rsp_id[c]];
      rsp_mapped  = busy[ch_rsp_id[c]];
      // Responses without an owner are drained so the slave never stalls on them
      slv_rsp_rdy = rstn && (rsp_mapped ? ch_rsp_rdy[c][rsp_owner] : 1'b1);
      rsp_hs      = ch_slv_rsp_vld[c] && slv_rsp_rdy && rsp_mapped;
    end

    assign ch_gnt[c]         = gnt;
    assign ch_gnt_vld[c]     = gnt_vld;
    assign ch_req_rdy[c]     = req_hs ? (NumPorts'(1) << gnt) : '0;
    assign ch_rsp_vld[c]     = (rstn && rsp_mapped && ch_slv_rsp_vld[c]) ?
                               (NumPorts'(1) << rsp_owner) : '0;
    assign ch_slv_rsp_rdy[c] = slv_rsp_rdy;
    assign ch_unmapped[c]    = ch_slv_rsp_vld[c] && slv_rsp_rdy && !rsp_mapped;
`ifdef XADAC_MUX_STATS_EN
    assign ch_stall[c]       = |masked;
`endif

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rr_ptr   <= '0;
        lock     <= 1'b0;
        lock_gnt <= '0;
        busy     <= '0;
        for (int i = 0; i < int'(NumIds); i++) owner[i] <= '0;
      end else begin
        if (req_hs) begin
          rr_ptr <= rr_next;
          lock   <= 1'b0;
        end else if (gnt_vld) begin
          lock     <= 1'b1;
          lock_gnt <= gnt;
        end
        // Set and clear never hit the same id: a busy id cannot be granted
        if (rsp_hs) busy[ch_rsp_id[c]] <= 1'b0;
        if (req_hs) begin
          busy[ch_req_id[c][gnt]]  <= 1'b1;
          owner[ch_req_id[c][gnt]] <= gnt;
        end
      end
    end

    lock_hold_a: assert property (@(posedge clk) disable iff (!rstn)
      lock |-> ch_req_vld[c][lock_gnt]);
  end

  assign slv.dec_req       = mst_dec_req[ch_gnt[0]];
  assign slv.dec_req_valid = ch_gnt_vld[0];
  assign slv.dec_rsp_ready = ch_slv_rsp_rdy[0];
  assign mst_dec_req_rdy   = ch_req_rdy[0];
  assign mst_dec_rsp       = slv.dec_rsp;
  assign mst_dec_rsp_vld   = ch_rsp_vld[0];

  assign slv.exe_req       = mst_exe_req[ch_gnt[1]];
  assign slv.exe_req_valid = ch_gnt_vld[1];
  assign slv.exe_rsp_ready = ch_slv_rsp_rdy[1];
  assign mst_exe_req_rdy   = ch_req_rdy[1];
  assign mst_exe_rsp       = slv.exe_rsp;
  assign mst_exe_rsp_vld   = ch_rsp_vld[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_unmapped <= 1'b0;
    else       err_unmapped <= ch_unmapped[0] | ch_unmapped[1];
  end

`ifdef XADAC_MUX_STATS_EN
  // Free-running statistics, wrapping at 2**32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        stat_dec_grants[p] <= '0;
        stat_exe_grants[p] <= '0;
      end
      stat_id_stalls <= '0;
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (ch_req_rdy[0][p]) stat_dec_grants[p] <= stat_dec_grants[p] + 32'd1;
        if (ch_req_rdy[1][p]) stat_exe_grants[p] <= stat_exe_grants[p] + 32'd1;
      end
      if (ch_stall[0] || ch_stall[1]) stat_id_stalls <= stat_id_stalls + 32'd1;
    end
  end
`endif

endmodule
